// File: rtl/xmem_arbiter.sv
// xmem_arbiter: round-robin arbiter sharing one xmem slave port among
// NUM_MASTERS xmem requesters, one transaction outstanding at a time.
//
// Ports:
//   aclk, aresetn        clock (rising edge), async active-low reset
//   s_xmem_*             upstream requester side, packed per master
//                        (master i occupies slice i of each vector)
//   m_xmem_*             downstream slave side (single port)
//   busy                 a transaction is in flight (state != IDLE)
//   owner                index of the current or most recent owner
//
// Flow: IDLE picks a winner starting at rr_ptr and registers it as
// owner; ISSUE forwards the owner's request and payload until the slave
// grants; WAIT_RSP routes the response back to the owner.  rr_ptr only
// advances on a completed transaction, so an abandoned request does not
// cost anyone their turn.

module xmem_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int XADDR_WIDTH = 32,
    parameter int XDATA_WIDTH = 32,
    parameter int IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic                               aclk,
    input  logic                               aresetn,

    input  logic [NUM_MASTERS-1:0]             s_xmem_req,
    input  logic [NUM_MASTERS*XADDR_WIDTH-1:0] s_xmem_addr,
    input  logic [NUM_MASTERS-1:0]             s_xmem_we,
    input  logic [NUM_MASTERS*XDATA_WIDTH-1:0] s_xmem_wdata,
    input  logic [NUM_MASTERS*XDATA_WIDTH/8-1:0] s_xmem_be,
    output logic [NUM_MASTERS-1:0]             s_xmem_gnt,
    output logic [NUM_MASTERS-1:0]             s_xmem_rsp_valid,
    output logic [XDATA_WIDTH-1:0]             s_xmem_rsp_rdata,
    output logic [NUM_MASTERS-1:0]             s_xmem_rsp_error,

    output logic                               m_xmem_req,
    output logic [XADDR_WIDTH-1:0]             m_xmem_addr,
    output logic                               m_xmem_we,
    output logic [XDATA_WIDTH-1:0]             m_xmem_wdata,
    output logic [XDATA_WIDTH/8-1:0]           m_xmem_be,
    input  logic                               m_xmem_gnt,
    input  logic                               m_xmem_rsp_valid,
    input  logic [XDATA_WIDTH-1:0]             m_xmem_rsp_rdata,
    input  logic                               m_xmem_rsp_error,

    output logic                               busy,
    output logic [IDX_WIDTH-1:0]               owner
);

    localparam int BE_WIDTH = XDATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    // ------------------------------------------------------------
    // Round-robin pick: first requesting master at or after rr_ptr.
    // ------------------------------------------------------------
    logic                 any_req;
    logic                 found;
    logic [IDX_WIDTH-1:0] pick;
    logic [IDX_WIDTH-1:0] cand;
    int                   cand_full;

    always_comb begin
        any_req   = |s_xmem_req;
        found     = 1'b0;
        pick      = rr_ptr_q;
        cand      = '0;
        cand_full = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_full = (int'(rr_ptr_q) + i) % NUM_MASTERS;
            cand      = IDX_WIDTH'(cand_full);
            if (!found && s_xmem_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Priority after a completion starts just past the finished owner,
    // so a master that re-requests immediately ranks last.
    logic [IDX_WIDTH-1:0] rr_next;

    always_comb begin
        if (owner_q == IDX_WIDTH'(NUM_MASTERS - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = owner_q + 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Owner decode and qualified handshake terms.
    // ------------------------------------------------------------
    logic                   in_issue;
    logic                   in_wait;
    logic                   sel_req;
    logic                   issue_gnt;
    logic                   rsp_fwd;
    logic [NUM_MASTERS-1:0] own_oh;

    always_comb begin
        in_issue  = (state_q == ISSUE);
        in_wait   = (state_q == WAIT_RSP);
        sel_req   = s_xmem_req[owner_q];
        own_oh    = NUM_MASTERS'(1) << owner_q;
        // A grant only counts while the owner still asserts its request;
        // otherwise the cycle is an abandon and nothing is issued.
        issue_gnt = in_issue & sel_req & m_xmem_gnt;
        // Responses are routed only in WAIT_RSP or on a zero-latency
        // grant+response; a stray rsp_valid anywhere else is dropped.
        rsp_fwd   = (in_wait & m_xmem_rsp_valid)
                  | (issue_gnt & m_xmem_rsp_valid);
    end

    // ------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!sel_req) begin
                    state_d = IDLE;
                end else if (m_xmem_gnt) begin
                    if (m_xmem_rsp_valid) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end else begin
                        state_d  = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (m_xmem_rsp_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------
    // Downstream request and payload mux (zero outside ISSUE).
    // ------------------------------------------------------------
    always_comb begin
        m_xmem_req   = in_issue & sel_req;
        m_xmem_addr  = '0;
        m_xmem_we    = 1'b0;
        m_xmem_wdata = '0;
        m_xmem_be    = '0;
        if (in_issue) begin
            m_xmem_addr  = s_xmem_addr[int'(owner_q)*XADDR_WIDTH +: XADDR_WIDTH];
            m_xmem_we    = s_xmem_we[owner_q];
            m_xmem_wdata = s_xmem_wdata[int'(owner_q)*XDATA_WIDTH +: XDATA_WIDTH];
            m_xmem_be    = s_xmem_be[int'(owner_q)*BE_WIDTH +: BE_WIDTH];
        end
    end

    // ------------------------------------------------------------
    // Upstream grant/response routing to the owner only.
    // ------------------------------------------------------------
    always_comb begin
        s_xmem_gnt       = issue_gnt ? own_oh : '0;
        s_xmem_rsp_valid = rsp_fwd ? own_oh : '0;
        s_xmem_rsp_error = (rsp_fwd & m_xmem_rsp_error) ? own_oh : '0;
        s_xmem_rsp_rdata = m_xmem_rsp_rdata;
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_xmem_arbiter.sv
// tb_xmem_arbiter: cycle table plus grant/response scoreboards
// for the 4-master xmem round-robin arbiter.

module tb_xmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    s_req;
    logic [N*AW-1:0] s_addr;
    logic [N-1:0]    s_we;
    logic [N*DW-1:0] s_wdata;
    logic [N*BW-1:0] s_be;
    logic [N-1:0]    s_gnt;
    logic [N-1:0]    s_rv;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    s_re;
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_we;
    logic [DW-1:0]   m_wdata;
    logic [BW-1:0]   m_be;
    logic            m_gnt;
    logic            m_rv;
    logic [DW-1:0]   m_rdata;
    logic            m_re;
    logic            busy;
    logic [1:0]      owner;

    xmem_arbiter #(
        .NUM_MASTERS (N),
        .XADDR_WIDTH (AW),
        .XDATA_WIDTH (DW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_xmem_req       (s_req),
        .s_xmem_addr      (s_addr),
        .s_xmem_we        (s_we),
        .s_xmem_wdata     (s_wdata),
        .s_xmem_be        (s_be),
        .s_xmem_gnt       (s_gnt),
        .s_xmem_rsp_valid (s_rv),
        .s_xmem_rsp_rdata (s_rdata),
        .s_xmem_rsp_error (s_re),
        .m_xmem_req       (m_req),
        .m_xmem_addr      (m_addr),
        .m_xmem_we        (m_we),
        .m_xmem_wdata     (m_wdata),
        .m_xmem_be        (m_be),
        .m_xmem_gnt       (m_gnt),
        .m_xmem_rsp_valid (m_rv),
        .m_xmem_rsp_rdata (m_rdata),
        .m_xmem_rsp_error (m_re),
        .busy             (busy),
        .owner            (owner)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] wd_t [N];
    logic [BW-1:0] be_t [N];

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        gnt;
        logic        rv;
        logic        re;
        logic [31:0] rd;
        logic [3:0]  eg;
        logic [3:0]  erv;
        logic [3:0]  ere;
        logic        emreq;
        logic        ebusy;
        logic [1:0]  eown;
        int          em;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    vec_t tbl[$];
    int   gnt_q[$];
    rsp_t rsp_q[$];

    function automatic vec_t mk(
        input logic [3:0] req, input logic [3:0] we,
        input logic gnt, input logic rv, input logic re,
        input logic [31:0] rd,
        input logic [3:0] eg, input logic [3:0] erv, input logic [3:0] ere,
        input logic emreq, input logic ebusy,
        input logic [1:0] eown, input int em);
        vec_t v;
        v.req = req;  v.we = we;   v.gnt = gnt;
        v.rv = rv;    v.re = re;   v.rd = rd;
        v.eg = eg;    v.erv = erv; v.ere = ere;
        v.emreq = emreq; v.ebusy = ebusy;
        v.eown = eown;   v.em = em;
        return v;
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Drive one cycle, queue its expected grant/response, check the
    // combinational outputs at the falling edge, then advance a cycle.
    task automatic drive_row(input int row, input vec_t v);
        logic [84:0] exp_v;
        logic [84:0] got_v;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        logic [BW-1:0] ebe;
        rsp_t r;
        s_req   = v.req;
        s_we    = v.we;
        m_gnt   = v.gnt;
        m_rv    = v.rv;
        m_re    = v.re;
        m_rdata = v.rd;
        if (v.eg != 4'b0) gnt_q.push_back(oh2idx(v.eg));
        if (v.erv != 4'b0) begin
            r.idx = oh2idx(v.erv);
            r.rd  = v.rd;
            r.err = |v.ere;
            rsp_q.push_back(r);
        end
        ea = '0; ewe = 1'b0; ewd = '0; ebe = '0;
        if (v.em >= 0) begin
            ea  = AW'(v.em * 4);
            ewe = v.we[v.em];
            ewd = wd_t[v.em];
            ebe = be_t[v.em];
        end
        exp_v = {v.eg, v.erv, v.ere, v.emreq, v.ebusy, v.eown,
                 ea, ewe, ewd, ebe};
        @(negedge aclk);
        got_v = {s_gnt, s_rv, s_re, m_req, busy, owner,
                 m_addr, m_we, m_wdata, m_be};
        chk($sformatf("row%0d", row), 128'(got_v), 128'(exp_v));
        @(posedge aclk);
        #1;
    endtask

    // Grant and response scoreboards.
    always @(negedge aclk) begin
        if (s_gnt != 4'b0) begin
            n_vec++;
            if (gnt_q.size() == 0) begin
                n_err++;
                $display("FAIL gnt_order: got %b want none", s_gnt);
            end else begin
                int e;
                e = gnt_q.pop_front();
                if (s_gnt !== 4'(1 << e)) begin
                    n_err++;
                    $display("FAIL gnt_order: got %b want %b",
                             s_gnt, 4'(1 << e));
                end
            end
        end
        if (s_rv != 4'b0) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_route: got %b want none", s_rv);
            end else begin
                rsp_t r;
                logic [39:0] g;
                logic [39:0] w;
                r = rsp_q.pop_front();
                g = {s_rv, s_re, s_rdata};
                w = {4'(1 << r.idx), r.err ? 4'(1 << r.idx) : 4'b0, r.rd};
                if (g !== w) begin
                    n_err++;
                    $display("FAIL rsp_route: got %h want %h", g, w);
                end
            end
        end
    end

    initial begin
        wd_t[0] = 32'ha5a5_0000; wd_t[1] = 32'h89ab_cdef;
        wd_t[2] = 32'ha5a5_0002; wd_t[3] = 32'ha5a5_0003;
        be_t[0] = 4'h1; be_t[1] = 4'hf; be_t[2] = 4'h3; be_t[3] = 4'hc;
        for (int i = 0; i < N; i++) begin
            s_addr[i*AW +: AW]  = AW'(i * 4);
            s_wdata[i*DW +: DW] = wd_t[i];
            s_be[i*BW +: BW]    = be_t[i];
        end
        s_req = '0; s_we = '0;
        m_gnt = 1'b0; m_rv = 1'b0; m_re = 1'b0; m_rdata = '0;

        // Scenario A: all four request from reset -> 0,1,2,3,0
        tbl.push_back(mk(4'hf,0,0,0,0,0,          0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'hf,0,1,0,0,0,          4'h1,0,0, 1,1,0,0));
        tbl.push_back(mk(4'hf,0,0,1,0,32'hd000_0000, 0,4'h1,0, 0,1,0,-1));
        tbl.push_back(mk(4'hf,0,0,0,0,0,          0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'hf,0,1,0,0,0,          4'h2,0,0, 1,1,1,1));
        tbl.push_back(mk(4'hf,0,0,1,0,32'hd000_0004, 0,4'h2,0, 0,1,1,-1));
        tbl.push_back(mk(4'hf,0,0,0,0,0,          0,0,0, 0,0,1,-1));
        tbl.push_back(mk(4'hf,0,1,0,0,0,          4'h4,0,0, 1,1,2,2));
        tbl.push_back(mk(4'hf,0,0,1,0,32'hd000_0008, 0,4'h4,0, 0,1,2,-1));
        tbl.push_back(mk(4'hf,0,0,0,0,0,          0,0,0, 0,0,2,-1));
        tbl.push_back(mk(4'hf,0,1,0,0,0,          4'h8,0,0, 1,1,3,3));
        tbl.push_back(mk(4'hf,0,0,1,0,32'hd000_000c, 0,4'h8,0, 0,1,3,-1));
        tbl.push_back(mk(4'hf,0,0,0,0,0,          0,0,0, 0,0,3,-1));
        tbl.push_back(mk(4'hf,0,1,0,0,0,          4'h1,0,0, 1,1,0,0));
        tbl.push_back(mk(4'hf,0,0,1,0,32'hd100_0000, 0,4'h1,0, 0,1,0,-1));
        // Scenario B: master 1 write, grant after two waits
        tbl.push_back(mk(4'h2,4'h2,0,0,0,0,       0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'h2,4'h2,0,0,0,0,       0,0,0, 1,1,1,1));
        tbl.push_back(mk(4'h2,4'h2,0,0,0,0,       0,0,0, 1,1,1,1));
        tbl.push_back(mk(4'h2,4'h2,1,0,0,0,       4'h2,0,0, 1,1,1,1));
        tbl.push_back(mk(4'h0,0,0,1,0,32'h0,      0,4'h2,0, 0,1,1,-1));
        // Scenario C: zero-latency slave on master 3, wrap to 0
        tbl.push_back(mk(4'h8,0,0,0,0,0,          0,0,0, 0,0,1,-1));
        tbl.push_back(mk(4'h8,0,1,1,0,32'h7654_3210, 4'h8,4'h8,0, 1,1,3,3));
        tbl.push_back(mk(4'h9,0,0,0,0,0,          0,0,0, 0,0,3,-1));
        tbl.push_back(mk(4'h9,0,1,0,0,0,          4'h1,0,0, 1,1,0,0));
        tbl.push_back(mk(4'h0,0,0,1,0,32'he000_0000, 0,4'h1,0, 0,1,0,-1));
        // Scenario D: master 2 abandons in ISSUE, master 0 served
        tbl.push_back(mk(4'h5,0,0,0,0,0,          0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'h5,0,0,0,0,0,          0,0,0, 1,1,2,2));
        tbl.push_back(mk(4'h1,0,0,0,0,0,          0,0,0, 0,1,2,2));
        tbl.push_back(mk(4'h1,0,0,0,0,0,          0,0,0, 0,0,2,-1));
        tbl.push_back(mk(4'h1,0,1,0,0,0,          4'h1,0,0, 1,1,0,0));
        tbl.push_back(mk(4'h0,0,0,1,0,32'he000_0004, 0,4'h1,0, 0,1,0,-1));
        // Scenario E: stray rsp in IDLE/ISSUE, error to master 1
        tbl.push_back(mk(4'h0,0,0,1,1,32'hbad0_0000, 0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'h2,0,0,0,0,0,          0,0,0, 0,0,0,-1));
        tbl.push_back(mk(4'h2,0,0,1,0,32'hbad0_0001, 0,0,0, 1,1,1,1));
        tbl.push_back(mk(4'h2,0,1,0,0,0,          4'h2,0,0, 1,1,1,1));
        tbl.push_back(mk(4'h0,0,0,1,1,32'he000_0008, 0,4'h2,4'h2, 0,1,1,-1));
        tbl.push_back(mk(4'h0,0,0,0,1,0,          0,0,0, 0,0,1,-1));

        // Outputs while held in reset
        #12;
        chk("reset_hold",
            128'({s_gnt, s_rv, s_re, s_rdata, m_req, m_addr, m_we,
                  m_wdata, m_be, busy, owner}), 128'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_row(i, tbl[i]);
        end

        // Reset while master 2 waits for its response
        s_req = 4'h4;
        @(negedge aclk);
        @(posedge aclk);
        #1;
        m_gnt = 1'b1;
        gnt_q.push_back(2);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        s_req = 4'h0;
        m_gnt = 1'b0;
        #1;
        chk("pre_reset", 128'({busy, owner}), 128'({1'b1, 2'd2}));
        #1;
        aresetn = 1'b0;
        m_rv    = 1'b1;
        m_re    = 1'b1;
        m_rdata = '0;
        #1;
        chk("reset_async",
            128'({s_gnt, s_rv, s_re, s_rdata, m_req, m_addr, m_we,
                  m_wdata, m_be, busy, owner}), 128'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_rv = 1'b0;
        m_re = 1'b0;
        drive_row(100, mk(4'h8,0,0,0,0,0,     0,0,0, 0,0,0,-1));
        drive_row(101, mk(4'h8,0,1,0,0,0,     4'h8,0,0, 1,1,3,3));
        drive_row(102, mk(4'h0,0,0,1,0,32'h3c3c_0003, 0,4'h8,0, 0,1,3,-1));

        chk("sb_drain", 128'({gnt_q.size(), rsp_q.size()}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
